// File: rtl/mem_model_2port.sv
// Two-port latency-configurable simulation memory: an instruction read port and a data
// read/write port over one shared array. Bounds checking is enabled by MEM_BOUNDS_CHECK_EN.
module mem_model_2port #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned IREAD_LAT  = 1,
  parameter int unsigned DREAD_LAT  = 1,
  parameter int unsigned DWRITE_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] iaddr,
  input  logic                  ire,
  output logic [DATA_WIDTH-1:0] irdata,
  output logic                  iready,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic                  dre,
  input  logic                  dwe,
  input  logic [DATA_WIDTH-1:0] dwdata,
  output logic [DATA_WIDTH-1:0] drdata,
  output logic                  drready,
  output logic                  dwack,
  output logic                  err
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  // Counter preload; a port in BUSY completes on the edge its counter reaches zero.
  localparam logic [3:0] ILoad  = 4'(IREAD_LAT - 1);
  localparam logic [3:0] DrLoad = 4'(DREAD_LAT - 1);
  localparam logic [3:0] DwLoad = 4'(DWRITE_LAT - 1);
  localparam bit         IImm   = (IREAD_LAT == 1);
  localparam bit         DrImm  = (DREAD_LAT == 1);
  localparam bit         DwImm  = (DWRITE_LAT == 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  logic [DATA_WIDTH-1:0] mem [Depth];

`ifdef MEM_BOUNDS_CHECK_EN
  function automatic logic addr_oob(input logic [ADDR_WIDTH-1:0] a);
    return |(a >> DEPTH_LOG2);
  endfunction
`endif

  function automatic logic [DATA_WIDTH-1:0] rd_word(input logic [ADDR_WIDTH-1:0] a);
`ifdef MEM_BOUNDS_CHECK_EN
    if (addr_oob(a)) return '1;
`endif
    return mem[a[DEPTH_LOG2-1:0]];
  endfunction

  // ---------------- Instruction port ----------------
  state_e                i_state_q, i_state_d;
  logic [3:0]            i_cnt_q, i_cnt_d;
  logic [ADDR_WIDTH-1:0] i_addr_q, i_addr_d;
  logic                  i_done;
  logic [ADDR_WIDTH-1:0] i_done_addr;

  always_comb begin
    i_state_d   = i_state_q;
    i_cnt_d     = i_cnt_q;
    i_addr_d    = i_addr_q;
    i_done      = 1'b0;
    i_done_addr = i_addr_q;
    unique case (i_state_q)
      StIdle: begin
        if (ire && !iready) begin
          i_addr_d = iaddr;
          if (IImm) begin
            i_done      = 1'b1;
            i_done_addr = iaddr;
          end else begin
            i_state_d = StBusy;
            i_cnt_d   = ILoad;
          end
        end
      end
      StBusy: begin
        i_cnt_d = i_cnt_q - 4'd1;
        if (i_cnt_q == 4'd1) begin
          i_done    = 1'b1;
          i_state_d = StIdle;
        end
      end
      default: i_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_state_q <= StIdle;
      i_cnt_q   <= '0;
      i_addr_q  <= '0;
      iready    <= 1'b0;
      irdata    <= '0;
    end else begin
      i_state_q <= i_state_d;
      i_cnt_q   <= i_cnt_d;
      i_addr_q  <= i_addr_d;
      iready    <= i_done;
      irdata    <= i_done ? rd_word(i_done_addr) : '0;
    end
  end

  // ---------------- Data port ----------------
  state_e                d_state_q, d_state_d;
  logic [3:0]            d_cnt_q, d_cnt_d;
  logic [ADDR_WIDTH-1:0] d_addr_q, d_addr_d;
  logic                  d_wr_q, d_wr_d;
  logic [DATA_WIDTH-1:0] d_wdata_q, d_wdata_d;
  logic                  d_rd_done, d_wr_done;
  logic [ADDR_WIDTH-1:0] d_done_addr;
  logic [DATA_WIDTH-1:0] d_done_wdata;
  logic                  mem_we;

  always_comb begin
    d_state_d    = d_state_q;
    d_cnt_d      = d_cnt_q;
    d_addr_d     = d_addr_q;
    d_wr_d       = d_wr_q;
    d_wdata_d    = d_wdata_q;
    d_rd_done    = 1'b0;
    d_wr_done    = 1'b0;
    d_done_addr  = d_addr_q;
    d_done_wdata = d_wdata_q;
    unique case (d_state_q)
      StIdle: begin
        // Write wins when both requests arrive together.
        if ((dre || dwe) && !drready && !dwack) begin
          d_addr_d  = daddr;
          d_wr_d    = dwe;
          d_wdata_d = dwdata;
          if (dwe ? DwImm : DrImm) begin
            d_rd_done    = !dwe;
            d_wr_done    = dwe;
            d_done_addr  = daddr;
            d_done_wdata = dwdata;
          end else begin
            d_state_d = StBusy;
            d_cnt_d   = dwe ? DwLoad : DrLoad;
          end
        end
      end
      StBusy: begin
        d_cnt_d = d_cnt_q - 4'd1;
        if (d_cnt_q == 4'd1) begin
          d_rd_done = !d_wr_q;
          d_wr_done = d_wr_q;
          d_state_d = StIdle;
        end
      end
      default: d_state_d = StIdle;
    endcase
  end

`ifdef MEM_BOUNDS_CHECK_EN
  assign mem_we = d_wr_done && !addr_oob(d_done_addr);
`else
  assign mem_we = d_wr_done;
`endif

  // mem sits outside the reset branch so reset leaves its contents intact.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_state_q <= StIdle;
      d_cnt_q   <= '0;
      d_addr_q  <= '0;
      d_wr_q    <= 1'b0;
      d_wdata_q <= '0;
      drready   <= 1'b0;
      drdata    <= '0;
      dwack     <= 1'b0;
    end else begin
      d_state_q <= d_state_d;
      d_cnt_q   <= d_cnt_d;
      d_addr_q  <= d_addr_d;
      d_wr_q    <= d_wr_d;
      d_wdata_q <= d_wdata_d;
      drready   <= d_rd_done;
      drdata    <= d_rd_done ? rd_word(d_done_addr) : '0;
      dwack     <= d_wr_done;
      if (mem_we) mem[d_done_addr[DEPTH_LOG2-1:0]] <= d_done_wdata;
    end
  end

`ifdef MEM_BOUNDS_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else begin
      if (i_done && addr_oob(i_done_addr)) begin
        err <= 1'b1;
        $display("mem_model_2port: I-port out-of-range address %h", i_done_addr);
      end
      if ((d_rd_done || d_wr_done) && addr_oob(d_done_addr)) begin
        err <= 1'b1;
        $display("mem_model_2port: D-port out-of-range address %h", d_done_addr);
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/mem_model_2port.md
Name: mem_model_2port

Overview:
- Parametrised, latency-configurable simulation memory replacing the single-port zero-wait memory used in the CPU testbench.
- Provides an independent instruction-fetch read port and a data read/write port. Both share one storage array.
- Every transaction completes with a one-cycle ready/ack handshake, so the CPU can be exercised against wait states.
- The storage array is named mem and is preloaded by the bench via $readmemh; reset never clears it.

Parameters:
- ADDR_WIDTH, 16, word-address width of both ports
- DATA_WIDTH, 16, word width
- DEPTH_LOG2, 10, log2 of number of words in mem
- IREAD_LAT, 1, clock edges from request sample to iready (1..15)
- DREAD_LAT, 1, clock edges from request sample to drready (1..15)
- DWRITE_LAT, 1, clock edges from request sample to dwack (1..15)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- iaddr  in  ADDR_WIDTH  instruction read address
- ire  in  1  instruction read request, held until iready
- irdata  out  DATA_WIDTH  instruction read data, valid while iready=1
- iready  out  1  one-cycle instruction read completion pulse
- daddr  in  ADDR_WIDTH  data address
- dre  in  1  data read request
- dwe  in  1  data write request
- dwdata  in  DATA_WIDTH  write data
- drdata  out  DATA_WIDTH  read data, valid while drready=1
- drready  out  1  one-cycle data read completion pulse
- dwack  out  1  one-cycle data write completion pulse
- err  out  1  sticky bounds-error flag (see Optional Feature)

Behaviour:
- Reset (rst=0, async): both port FSMs go to IDLE; iready, drready, dwack, err = 0; irdata, drdata = 0; latency counters = 0; mem untouched.
- Reset asserted mid-transaction aborts it: no ready/ack pulse is produced, and no write occurs if the write had not yet completed.
- Per-port FSM has states IDLE, BUSY.
  - IDLE -> BUSY: at an edge where the request is high and the port's ready/ack output is 0. Address and write data are captured at this edge; later input changes are ignored. The counter is loaded with LAT-1.
  - LAT=1: the transaction completes at the sampling edge itself. The FSM stays IDLE and the ready/ack pulse appears after that edge.
  - BUSY: the counter decrements each edge. At the edge where the counter is 0, the transaction completes, the ready/ack output registers to 1 for exactly one cycle, and the FSM returns to IDLE.
- A request still high during the ready/ack cycle is the completed request and is not re-sampled. A new request is sampled at the following edge at the earliest, so the minimum request period is LAT+1 cycles.
- D-port: if dre and dwe are both high at the sampling edge, the write wins and the read is dropped (no drready).
- Read data is taken from mem at the completing edge and held on irdata/drdata only during the ready cycle. It is 0 otherwise.
- Write updates mem at the completing edge.
- Write/read collision: if a write and a read (either port) to the same word complete at the same edge, the read returns the old data. Reads completing at later edges see the new data.
- Address indexing: mem index = addr[DEPTH_LOG2-1:0]. Upper address bits alias (wrap-around) unless MEM_BOUNDS_CHECK_EN is defined.
- The I-port and D-port operate fully independently; neither stalls the other.

Optional Feature:
- Macro MEM_BOUNDS_CHECK_EN.
- Defined: a sampled address with any bit at or above DEPTH_LOG2 set is out of range.
  - Out-of-range reads complete normally with data all-ones.
  - Out-of-range writes complete with dwack but do not modify mem.
  - err is set at the completing edge and stays 1 until reset; $display prints the port and address.
- Undefined: addresses alias as described above, and err is tied to 0.

Test Plan:
- Reset and idle: hold rst=0 for 3 cycles with ire=1. Require iready=0, irdata=0, err=0; after release, first iready appears 1 edge later (IREAD_LAT=1) with irdata=mem[iaddr] from preload.
- Latency: IREAD_LAT=3, ire held with iaddr=0x0004. Require iready high exactly the third cycle after sampling; back-to-back requests complete every 4 cycles.
- Write then read: DWRITE_LAT=2, dwe with daddr=0x0010, dwdata=0xBEEF gives dwack after 2 edges. A following dre to 0x0010 gives drdata=0xBEEF.
- Collision and priority:
  - dre=dwe=1 at the same edge: only dwack pulses, never drready.
  - I-read of 0x0010 completing on the same edge as a D-write 0xCAFE to 0x0010 returns the old value 0xBEEF.
- Reset mid-operation: DWRITE_LAT=4, write 0x1234 to 0x0020, assert rst after 2 edges. Require no dwack, mem[0x20] unchanged, and the FSM in IDLE after release.
- Bounds (MEM_BOUNDS_CHECK_EN, DEPTH_LOG2=10): read 0x0400 returns 0xFFFF with err=1 sticky. Without the macro, the same read returns mem[0x000] and err stays 0.
